mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin front end for a single-port RAM.
// One transaction in flight at a time, three cycles each: IDLE (grant),
// ISSUE (drive RAM), RESP (return RAM result to the owning requester).
module mem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_valid,
    output logic              m0_ready,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_we,
    output logic              m0_resp_valid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_error,

    input  logic              m1_valid,
    output logic              m1_ready,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_we,
    output logic              m1_resp_valid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_error,

    output logic [ADDR_W-1:0] rw_addr,
    output logic [DATA_W-1:0] rw_data_in,
    output logic              rw_write_en,
    input  logic [DATA_W-1:0] rw_data_out,
    input  logic              rw_error,

    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    // Latched transaction and arbitration history
    logic              last_grant;   // 1: m1 was granted last, so m0 wins a tie
    logic              owner;        // requester of the transaction in flight
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_we;

    // Held response values per requester
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    logic              err0_q;
    logic              err1_q;

    logic              pick0;
    logic              pick1;
    logic              hs0;
    logic              hs1;
    logic              misaligned;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    // Round-robin selection: a sole requester wins, a tie goes to the one not granted last
    always_comb begin
        pick0 = m0_valid && (!m1_valid || last_grant);
        pick1 = m1_valid && (!m0_valid || !last_grant);
    end

    // Handshakes and address alignment of the latched request
    always_comb begin
        hs0        = m0_valid && m0_ready;
        hs1        = m1_valid && m1_ready;
        misaligned = |lat_addr[2:0];
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: a handshake starts a transaction, then ISSUE and RESP follow unconditionally
    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:    next_state = (hs0 || hs1) ? ISSUE : IDLE;
            ISSUE:   next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM outputs; reset masks ready, write enable and response strobe in the cycle it is asserted
    always_comb begin
        m0_ready      = 1'b0;
        m1_ready      = 1'b0;
        m0_resp_valid = 1'b0;
        m1_resp_valid = 1'b0;
        rw_addr       = '0;
        rw_data_in    = '0;
        rw_write_en   = 1'b0;
        busy          = (state != IDLE);
        case (state)
            IDLE: begin
                m0_ready = pick0 && !reset;
                m1_ready = pick1 && !reset;
            end
            ISSUE: begin
                rw_addr     = lat_addr;
                rw_data_in  = lat_wdata;
                rw_write_en = lat_we && !misaligned && !reset;
            end
            RESP: begin
                rw_addr       = lat_addr;
                rw_data_in    = lat_wdata;
                m0_resp_valid = !owner && !reset;
                m1_resp_valid = owner && !reset;
            end
            default: ;
        endcase
    end

    // Response value: RAM data only for aligned reads; misalignment always reports an error
    always_comb begin
        resp_rdata = (lat_we || misaligned) ? '0 : rw_data_out;
        resp_err   = misaligned || rw_error;
    end

    // Response outputs show the live RAM result during the strobe and the held value otherwise
    always_comb begin
        m0_rdata = m0_resp_valid ? resp_rdata : rdata0_q;
        m0_error = m0_resp_valid ? resp_err   : err0_q;
        m1_rdata = m1_resp_valid ? resp_rdata : rdata1_q;
        m1_error = m1_resp_valid ? resp_err   : err1_q;
    end

    // Request latch, grant history and per-requester response holding registers
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_we     <= 1'b0;
            rdata0_q   <= '0;
            err0_q     <= 1'b0;
            rdata1_q   <= '0;
            err1_q     <= 1'b0;
        end else begin
            if (hs0 || hs1) begin
                owner      <= hs1;
                last_grant <= hs1;
                lat_addr   <= hs1 ? m1_addr  : m0_addr;
                lat_wdata  <= hs1 ? m1_wdata : m0_wdata;
                lat_we     <= hs1 ? m1_we    : m0_we;
            end
            if (m0_resp_valid) begin
                rdata0_q <= resp_rdata;
                err0_q   <= resp_err;
            end
            if (m1_resp_valid) begin
                rdata1_q <= resp_rdata;
                err1_q   <= resp_err;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized requests from both requesters
// against a transaction-level reference model and a small RAM model.
module tb_mem_arbiter;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        m0_valid, m0_ready, m0_we, m0_resp_valid, m0_error;
    logic [63:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_valid, m1_ready, m1_we, m1_resp_valid, m1_error;
    logic [63:0] m1_addr, m1_wdata, m1_rdata;
    logic [63:0] rw_addr, rw_data_in, rw_data_out;
    logic        rw_write_en, rw_error, busy;

    int checks = 0;
    int failures = 0;

    mem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_we(m0_we), .m0_resp_valid(m0_resp_valid), .m0_rdata(m0_rdata), .m0_error(m0_error),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_we(m1_we), .m1_resp_valid(m1_resp_valid), .m1_rdata(m1_rdata), .m1_error(m1_error),
        .rw_addr(rw_addr), .rw_data_in(rw_data_in), .rw_write_en(rw_write_en),
        .rw_data_out(rw_data_out), .rw_error(rw_error), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: 64 words, registered read data; addresses with bit 8 set report an error
    logic [63:0] ram [0:63];
    logic [63:0] ram_q;
    logic        ram_err_q;
    initial begin
        for (int i = 0; i < 64; i++) ram[i] = '0;
        ram_q = '0;
        ram_err_q = 1'b0;
    end
    always @(posedge clk) begin
        if (rw_write_en) ram[rw_addr[8:3]] <= rw_data_in;
        ram_q     <= ram[rw_addr[8:3]];
        ram_err_q <= rw_addr[8];
    end
    assign rw_data_out = ram_q;
    assign rw_error    = ram_err_q;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model state: transaction-level view of the arbiter
    logic [63:0] mdl_mem [logic [63:0]];
    exp_t        q0[$];
    exp_t        q1[$];
    int          ph = 0;          // cycles into current transaction: 0 idle, 1 RAM access, 2 response
    int          own = 0;
    int          win;
    logic        last = 1'b1;
    logic [63:0] cur_a, cur_d;
    logic        cur_w;
    exp_t        cur_e;
    logic [63:0] held_r [2];
    logic        held_e [2];

    function automatic logic [63:0] mem_rd(input logic [63:0] a);
        return mdl_mem.exists(a) ? mdl_mem[a] : 64'd0;
    endfunction

    // Cycle-by-cycle expectations; pushes the expected response at grant time
    always @(negedge clk) begin
        if (reset) begin
            check("rst_m0_ready", m0_ready, 1'b0);
            check("rst_m1_ready", m1_ready, 1'b0);
            check("rst_m0_resp_valid", m0_resp_valid, 1'b0);
            check("rst_m1_resp_valid", m1_resp_valid, 1'b0);
            ph = 0;
            last = 1'b1;
            held_r[0] = '0; held_r[1] = '0;
            held_e[0] = 1'b0; held_e[1] = 1'b0;
            q0.delete();
            q1.delete();
        end else begin
            check("busy", busy, ph != 0);
            win = -1;
            if (ph == 0) begin
                if (m0_valid && m1_valid) win = last ? 0 : 1;
                else if (m0_valid) win = 0;
                else if (m1_valid) win = 1;
            end
            check("m0_ready", m0_ready, win == 0);
            check("m1_ready", m1_ready, win == 1);
            if (ph == 1) begin
                check("rw_addr_issue", rw_addr, cur_a);
                check("rw_data_in_issue", rw_data_in, cur_d);
                check("rw_write_en_issue", rw_write_en, cur_w && (cur_a[2:0] == 3'd0));
            end else if (ph == 2) begin
                check("rw_write_en_resp", rw_write_en, 1'b0);
            end else begin
                check("rw_addr_idle", rw_addr, 64'd0);
                check("rw_data_in_idle", rw_data_in, 64'd0);
                check("rw_write_en_idle", rw_write_en, 1'b0);
            end
            check("m0_resp_valid", m0_resp_valid, ph == 2 && own == 0);
            check("m1_resp_valid", m1_resp_valid, ph == 2 && own == 1);
            if (!(ph == 2 && own == 0)) begin
                check("m0_rdata_hold", m0_rdata, held_r[0]);
                check("m0_error_hold", m0_error, held_e[0]);
            end
            if (!(ph == 2 && own == 1)) begin
                check("m1_rdata_hold", m1_rdata, held_r[1]);
                check("m1_error_hold", m1_error, held_e[1]);
            end
            case (ph)
                0: if (win >= 0) begin
                    own   = win;
                    last  = (win == 1);
                    cur_a = (win == 1) ? m1_addr  : m0_addr;
                    cur_d = (win == 1) ? m1_wdata : m0_wdata;
                    cur_w = (win == 1) ? m1_we    : m0_we;
                    if (cur_a[2:0] != 3'd0) begin
                        cur_e.rdata = '0; cur_e.err = 1'b1;
                    end else if (cur_w) begin
                        cur_e.rdata = '0; cur_e.err = cur_a[8];
                    end else begin
                        cur_e.rdata = mem_rd(cur_a); cur_e.err = cur_a[8];
                    end
                    if (win == 1) q1.push_back(cur_e);
                    else q0.push_back(cur_e);
                    ph = 1;
                end
                1: begin
                    if (cur_w && cur_a[2:0] == 3'd0) mdl_mem[cur_a] = cur_d;
                    ph = 2;
                end
                default: begin
                    held_r[own] = cur_e.rdata;
                    held_e[own] = cur_e.err;
                    ph = 0;
                end
            endcase
        end
    end

    // Scoreboard monitor: pops an expected response whenever the DUT strobes one
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (m0_resp_valid) begin
                if (q0.size() == 0) begin
                    check("m0_resp_unexpected", 64'd1, 64'd0);
                end else begin
                    e = q0.pop_front();
                    check("m0_rdata", m0_rdata, e.rdata);
                    check("m0_error", m0_error, e.err);
                end
            end
            if (m1_resp_valid) begin
                if (q1.size() == 0) begin
                    check("m1_resp_unexpected", 64'd1, 64'd0);
                end else begin
                    e = q1.pop_front();
                    check("m1_rdata", m1_rdata, e.rdata);
                    check("m1_error", m1_error, e.err);
                end
            end
        end
    end

    task automatic drive(input int n, input logic v, input logic [63:0] a,
                         input logic [63:0] d, input logic w);
        if (n == 0) begin
            m0_valid = v; m0_addr = a; m0_wdata = d; m0_we = w;
        end else begin
            m1_valid = v; m1_addr = a; m1_wdata = d; m1_we = w;
        end
    endtask

    task automatic drop(input int n);
        if (n == 0) m0_valid = 1'b0;
        else m1_valid = 1'b0;
    endtask

    function automatic logic rdy(input int n);
        return (n == 0) ? m0_ready : m1_ready;
    endfunction

    // Present a request and hold it until the handshake (bounded); called at posedge+1
    task automatic req(input int n, input logic [63:0] a, input logic [63:0] d, input logic w);
        int cyc = 0;
        drive(n, 1'b1, a, d, w);
        while (1) begin
            @(negedge clk);
            if (!reset && rdy(n)) break;
            cyc++;
            if (cyc > 50) begin
                check($sformatf("m%0d_handshake_timeout", n), 64'd1, 64'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        drop(n);
    endtask

    // Random request; some are withdrawn after one cycle if not accepted
    task automatic rand_req(input int n);
        logic [63:0] a, d;
        logic w;
        a = 64'($urandom_range(0, 63)) * 64'd8;
        if ($urandom_range(0, 4) == 0) a = a + 64'($urandom_range(1, 7));
        d = {$urandom, $urandom};
        w = $urandom_range(0, 1) == 1;
        if ($urandom_range(0, 99) < 15) begin
            drive(n, 1'b1, a, d, w);
            @(negedge clk);
            @(posedge clk);
            #1;
            drop(n);
        end else begin
            req(n, a, d, w);
        end
    endtask

    task automatic rand_stream(input int n, input int count);
        int g;
        for (int k = 0; k < count; k++) begin
            g = $urandom_range(0, 3);
            if (g > 0) begin
                repeat (g) @(posedge clk);
                #1;
            end
            rand_req(n);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        reset = 1'b1;
        drive(0, 1'b0, '0, '0, 1'b0);
        drive(1, 1'b0, '0, '0, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Write then read back, misaligned write must not disturb memory
        req(0, 64'h10, 64'hDEAD, 1'b1);
        req(1, 64'h10, 64'h0, 1'b0);
        req(0, 64'h13, 64'hBEEF, 1'b1);
        req(1, 64'h10, 64'h0, 1'b0);
        req(1, 64'h14, 64'h0, 1'b0);
        // RAM error region: error flag with RAM data on reads
        req(0, 64'h110, 64'h1234, 1'b1);
        req(1, 64'h110, 64'h0, 1'b0);

        // Reset during the RAM-access cycle of an m1 write aborts it
        drive(1, 1'b1, 64'h20, 64'h5555, 1'b1);
        cyc = 0;
        while (1) begin
            @(negedge clk);
            if (m1_ready) break;
            cyc++;
            if (cyc > 50) begin
                check("m1_abort_handshake_timeout", 64'd1, 64'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        drop(1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        fork
            req(0, 64'h20, 64'h0, 1'b0);
            req(1, 64'h10, 64'h0, 1'b0);
        join

        // Both requesters valid through reset and continuously afterwards
        @(posedge clk);
        #1 reset = 1'b1;
        fork
            begin repeat (3) req(0, 64'h10, 64'h0, 1'b0); end
            begin repeat (3) req(1, 64'h110, 64'h0, 1'b0); end
            begin repeat (2) @(posedge clk); #1 reset = 1'b0; end
        join

        // Randomized traffic from both requesters
        fork
            rand_stream(0, 40);
            rand_stream(1, 40);
        join

        repeat (6) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(q0.size() + q1.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
